// File: rtl/motor_drive_sequencer.sv
// Two-channel motor PWM/direction sequencer with dead-time-protected reversal; define SOFT_RAMP_EN for 1-LSB-per-wrap duty ramping.
// Latency: duty changes take effect at the next PWM wrap; a reversal holds enable low for DEADTIME_CYC cycles before the direction flips.
// Backpressure: cmd_ready drops while the addressed channel's slot is full, it is in dead time, or estop is high.
module motor_drive_sequencer #(
    parameter int PWM_BITS     = 8,
    parameter int PWM_PRESCALE = 39,
    parameter int DEADTIME_CYC = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_motor,
    input  logic                cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic                estop,
    output logic                left_dir,
    output logic                left_en,
    output logic                right_dir,
    output logic                right_en,
    output logic                left_busy,
    output logic                right_busy
);
    localparam int PS_W = (PWM_PRESCALE < 1) ? 1 : $clog2(PWM_PRESCALE + 1);
    localparam int DT_W = $clog2(DEADTIME_CYC);

`ifdef SOFT_RAMP_EN
    typedef enum logic [1:0] {IDLE, RUN, DEAD, RAMPDN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
`endif

    logic [1:0]          dir_w, en_w, busy_w, slot_full_w, in_dead_w;
    logic [PS_W-1:0]     pre_q;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick, wrap;

    always_comb begin
        tick  = (pre_q == PS_W'(PWM_PRESCALE));
        wrap  = tick && (pwm_q == {PWM_BITS{1'b1}});
        pwm_d = tick ? pwm_q + 1'b1 : pwm_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            pwm_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            pwm_q <= pwm_d;
        end
    end

    assign cmd_ready = !estop && !slot_full_w[cmd_motor] && !in_dead_w[cmd_motor];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t              state_q, state_d;
        logic                dir_q, dir_d, en_q, en_d;
        logic                pend_vld_q, pend_vld_d, pend_dir_q, pend_dir_d;
        logic                hold_dir_q, hold_dir_d;
        logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d, hold_duty_q, hold_duty_d;
        logic [PWM_BITS-1:0] target_q, target_d, applied_q, applied_d;
        logic [DT_W-1:0]     dead_q, dead_d;
        logic                accept, consume;

        assign accept         = cmd_valid && cmd_ready && (cmd_motor == 1'(c));
        assign dir_w[c]       = dir_q;
        assign en_w[c]        = en_q;
        assign busy_w[c]      = (state_q != IDLE) || pend_vld_q;
        assign slot_full_w[c] = pend_vld_q;
        assign in_dead_w[c]   = (state_q == DEAD);

        always_comb begin
            state_d     = state_q;
            dir_d       = dir_q;
            target_d    = target_q;
            applied_d   = applied_q;
            hold_dir_d  = hold_dir_q;
            hold_duty_d = hold_duty_q;
            dead_d      = dead_q;
            consume     = 1'b0;

            // Duty only moves on the wrap so no PWM period is ever truncated.
            if (wrap) begin
`ifdef SOFT_RAMP_EN
                if (applied_q < target_q)
                    applied_d = applied_q + 1'b1;
                else if (applied_q > target_q)
                    applied_d = applied_q - 1'b1;
`else
                applied_d = target_q;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (pend_vld_q) begin
                        consume = 1'b1;
                        if (pend_dir_q == dir_q) begin
                            state_d  = RUN;
                            target_d = pend_duty_q;
                        end else begin
                            state_d     = DEAD;
                            dead_d      = DT_W'(DEADTIME_CYC - 1);
                            hold_dir_d  = pend_dir_q;
                            hold_duty_d = pend_duty_q;
                        end
                    end
                end
                RUN: begin
                    if (pend_vld_q && (pend_dir_q == dir_q)) begin
                        consume  = 1'b1;
                        target_d = pend_duty_q;
                    end else if (pend_vld_q) begin
`ifdef SOFT_RAMP_EN
                        state_d  = RAMPDN;
                        target_d = '0;
`else
                        consume     = 1'b1;
                        state_d     = DEAD;
                        dead_d      = DT_W'(DEADTIME_CYC - 1);
                        hold_dir_d  = pend_dir_q;
                        hold_duty_d = pend_duty_q;
                        target_d    = '0;
                        applied_d   = '0;
`endif
                    end else if (target_q == '0 && applied_q == '0) begin
                        state_d = IDLE;
                    end
                end
`ifdef SOFT_RAMP_EN
                RAMPDN: begin
                    target_d = '0;
                    if (applied_q == '0) begin
                        consume     = 1'b1;
                        state_d     = DEAD;
                        dead_d      = DT_W'(DEADTIME_CYC - 1);
                        hold_dir_d  = pend_dir_q;
                        hold_duty_d = pend_duty_q;
                    end
                end
`endif
                DEAD: begin
                    target_d  = '0;
                    applied_d = '0;
                    if (dead_q == '0) begin
                        state_d  = RUN;
                        dir_d    = hold_dir_q;
                        target_d = hold_duty_q;
                    end else begin
                        dead_d = dead_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            pend_vld_d  = pend_vld_q && !consume;
            pend_dir_d  = pend_dir_q;
            pend_duty_d = pend_duty_q;
            if (accept) begin
                pend_vld_d  = 1'b1;
                pend_dir_d  = cmd_dir;
                pend_duty_d = cmd_duty;
            end

            // Direction is held so a later reversal still goes through dead time.
            if (estop) begin
                state_d    = IDLE;
                dir_d      = dir_q;
                pend_vld_d = 1'b0;
                target_d   = '0;
                applied_d  = '0;
            end

            // Enable is computed from next-state values so it falls on the same edge the FSM leaves RUN.
`ifdef SOFT_RAMP_EN
            en_d = ((state_d == RUN) || (state_d == RAMPDN)) && (pwm_d < applied_d);
`else
            en_d = (state_d == RUN) && (pwm_d < applied_d);
`endif
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= IDLE;
                dir_q       <= 1'b0;
                en_q        <= 1'b0;
                pend_vld_q  <= 1'b0;
                pend_dir_q  <= 1'b0;
                pend_duty_q <= '0;
                hold_dir_q  <= 1'b0;
                hold_duty_q <= '0;
                target_q    <= '0;
                applied_q   <= '0;
                dead_q      <= '0;
            end else begin
                state_q     <= state_d;
                dir_q       <= dir_d;
                en_q        <= en_d;
                pend_vld_q  <= pend_vld_d;
                pend_dir_q  <= pend_dir_d;
                pend_duty_q <= pend_duty_d;
                hold_dir_q  <= hold_dir_d;
                hold_duty_q <= hold_duty_d;
                target_q    <= target_d;
                applied_q   <= applied_d;
                dead_q      <= dead_d;
            end
        end
    end

    assign left_dir   = dir_w[0];
    assign left_en    = en_w[0];
    assign left_busy  = busy_w[0];
    assign right_dir  = dir_w[1];
    assign right_en   = en_w[1];
    assign right_busy = busy_w[1];

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer (default build): PWM duty tables, reversal dead time, estop and reset.
module tb_motor_drive_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_motor = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_duty = 4'd0;
    logic       estop = 1'b0;
    logic       cmd_ready, left_dir, left_en, right_dir, right_en, left_busy, right_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    motor_drive_sequencer #(
        .PWM_BITS(4),
        .PWM_PRESCALE(1),
        .DEADTIME_CYC(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_motor(cmd_motor),
        .cmd_dir(cmd_dir),
        .cmd_duty(cmd_duty),
        .estop(estop),
        .left_dir(left_dir),
        .left_en(left_en),
        .right_dir(right_dir),
        .right_en(right_en),
        .left_busy(left_busy),
        .right_busy(right_busy)
    );

    typedef struct {
        logic       m;
        logic       d;
        logic [3:0] duty;
        int         lcnt;
        logic       ldir;
        logic       lbusy;
        int         rcnt;
        logic       rdir;
        logic       rbusy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic send(input logic m, input logic d, input logic [3:0] du);
        logic done;
        done = 1'b0;
        @(negedge clk);
        cmd_motor = m;
        cmd_dir   = d;
        cmd_duty  = du;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 cmd_valid = 1'b0;
        chk("send accepted", int'(done), 1);
    endtask

    task automatic count_en(input logic m, output int cnt);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cnt += int'(m ? right_en : left_en);
        end
    endtask

    // Cycles from the accepting edge until the direction output flips; en_hi counts enable-high samples meanwhile.
    task automatic measure_rev(input logic m, output int n, output int en_hi);
        logic start_dir;
        start_dir = m ? right_dir : left_dir;
        n = 0;
        en_hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            en_hi += int'(m ? right_en : left_en);
            if ((m ? right_dir : left_dir) != start_dir) break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc, rc, n, hi, waited;
        logic found;

        tbl[0] = '{1'b0, 1'b0, 4'd4,  8,  1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'd8,  16, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'd8,  16, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'd15, 30, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'd0,  0,  1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'd2,  0,  1'b1, 1'b0, 4, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 4'd1,  0,  1'b1, 1'b0, 2, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 4'd3,  6,  1'b0, 1'b1, 2, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset left_en", int'(left_en), 0);
        chk("reset right_en", int'(right_en), 0);
        chk("reset left_dir", int'(left_dir), 0);
        chk("reset right_dir", int'(right_dir), 0);
        chk("reset left_busy", int'(left_busy), 0);
        chk("reset right_busy", int'(right_busy), 0);
        chk("reset cmd_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].m, tbl[i].d, tbl[i].duty);
            repeat (100) @(negedge clk);
            count_en(1'b0, lc);
            count_en(1'b1, rc);
            chk($sformatf("row%0d left_en highs", i), lc, tbl[i].lcnt);
            chk($sformatf("row%0d right_en highs", i), rc, tbl[i].rcnt);
            chk($sformatf("row%0d left_dir", i), int'(left_dir), int'(tbl[i].ldir));
            chk($sformatf("row%0d right_dir", i), int'(right_dir), int'(tbl[i].rdir));
            chk($sformatf("row%0d left_busy", i), int'(left_busy), int'(tbl[i].lbusy));
            chk($sformatf("row%0d right_busy", i), int'(right_busy), int'(tbl[i].rbusy));
        end

        // Reversal from RUN: exactly 16 dead cycles after the consume edge, enable low throughout.
        send(1'b0, 1'b0, 4'd8);
        repeat (70) @(negedge clk);
        send(1'b0, 1'b1, 4'd8);
        measure_rev(1'b0, n, hi);
        chk("rev cycles to dir flip", n, 17);
        chk("rev en highs in dead", hi, 0);
        chk("rev left_dir after", int'(left_dir), 1);
        repeat (70) @(negedge clk);
        count_en(1'b0, lc);
        chk("rev pwm resumes", lc, 16);

        // Right channel unaffected by left dead time; left blocked until dead time ends.
        send(1'b0, 1'b0, 4'd5);
        repeat (3) @(negedge clk);
        cmd_motor = 1'b0;
        #1;
        chk("dead left cmd_ready", int'(cmd_ready), 0);
        cmd_motor = 1'b1;
        #1;
        chk("dead right cmd_ready", int'(cmd_ready), 1);
        send(1'b1, 1'b1, 4'd6);
        cmd_motor = 1'b0;
        found = 1'b0;
        waited = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            waited++;
            if (cmd_ready) found = 1'b1;
        end
        chk("left ready after dead", int'(found), 1);
        chk("left dir flipped at ready", int'(left_dir), 0);
        repeat (70) @(negedge clk);
        count_en(1'b0, lc);
        count_en(1'b1, rc);
        chk("post dead left highs", lc, 10);
        chk("post dead right highs", rc, 12);

        // One-cycle estop.
        @(negedge clk);
        estop = 1'b1;
        #1;
        chk("estop cmd_ready", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        estop = 1'b0;
        chk("estop left_en", int'(left_en), 0);
        chk("estop right_en", int'(right_en), 0);
        chk("estop left_busy", int'(left_busy), 0);
        chk("estop right_busy", int'(right_busy), 0);
        chk("estop left_dir held", int'(left_dir), 0);
        chk("estop right_dir held", int'(right_dir), 1);
        repeat (40) @(negedge clk);
        count_en(1'b0, lc);
        count_en(1'b1, rc);
        chk("after estop left idle", lc, 0);
        chk("after estop right idle", rc, 0);
        send(1'b1, 1'b1, 4'd2);
        repeat (70) @(negedge clk);
        count_en(1'b1, rc);
        chk("restart right highs", rc, 4);
        send(1'b0, 1'b1, 4'd5);
        measure_rev(1'b0, n, hi);
        chk("post estop rev cycles", n, 17);
        chk("post estop rev en highs", hi, 0);
        repeat (70) @(negedge clk);
        count_en(1'b0, lc);
        chk("post estop left highs", lc, 10);

        // Asynchronous reset mid-run.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun reset left_en", int'(left_en), 0);
        chk("midrun reset right_en", int'(right_en), 0);
        chk("midrun reset left_dir", int'(left_dir), 0);
        chk("midrun reset right_dir", int'(right_dir), 0);
        chk("midrun reset left_busy", int'(left_busy), 0);
        chk("midrun reset right_busy", int'(right_busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        count_en(1'b0, lc);
        count_en(1'b1, rc);
        chk("after reset left idle", lc, 0);
        chk("after reset right idle", rc, 0);
        chk("after reset left_busy", int'(left_busy), 0);
        chk("after reset right_busy", int'(right_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
